waveform_reader: RTL

Display-side reader for the double-buffered scope capture RAMs. Scans the committed integrator and comparator buffers in step with the video raster and renders both traces as 12-bit RGB pixels. Issues the once-per-frame `can_commit` pulse that lets the capture side swap buffers only during vertical blanking. Sits between the capture block's read ports and the VGA output stage.

---
 rtl/waveform_reader.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/waveform_reader.sv
// waveform_reader
//
// Display-side reader for the double-buffered scope capture RAMs. The reader
// walks the committed integrator and comparator buffers one sample per
// raster column and renders both traces as 12-bit RGB pixels. It also issues
// the once-per-frame can_commit pulse, which lets the capture side swap
// buffers only during vertical blanking.
//
// Pipeline (hcount/vcount presented in cycle n):
//   A (edge n+1): RAM address, out-of-range flag, raster row, syncs, blank
//   B (edge n+2): RAM data valid; sample rows computed combinationally
//   C (edge n+3): pixel and delayed syncs/blank registered
//
// Build option:
//   WAVEFORM_CONNECT_EN  defined   -> each trace is drawn as a connected line
//                                     (vertical run from previous sample row)
//                        undefined -> dot plot, no previous-sample registers
//
// Ports:
//   clk              pixel/system clock
//   reset            asynchronous, active-high
//   hcount[10:0]     raster column (>= H_ACTIVE is off-screen, drawn black)
//   vcount[9:0]      raster row
//   hsync_in, vsync_in, blank_in   raster timing in
//   freeze           suppresses can_commit (holds the current display)
//   integrator_dout  integrator buffer data for waveform_addr, 1-cycle latency
//   comparator_dout  comparator buffer data for waveform_addr, 1-cycle latency
//   waveform_addr    buffer read address (hcount[9:0], registered)
//   can_commit       single-cycle buffer-swap permission
//   pixel[11:0]      RGB 4:4:4
//   hsync_out, vsync_out, blank_out   timing delayed to line up with pixel
//
// Commit FSM:
//   state  | meaning
//   DRAW   | active video; waiting for vcount to reach V_ACTIVE
//   VBLANK | pulse already issued this frame; waiting for vcount == 0

module waveform_reader #(
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 768,
    parameter int          INT_BASE  = 300,
    parameter int          CMP_BASE  = 700,
    parameter int          VSHIFT    = 2,
    parameter logic [11:0] INT_COLOR = 12'h0F0,
    parameter logic [11:0] CMP_COLOR = 12'hFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic        freeze,
    input  logic [9:0]  integrator_dout,
    input  logic [9:0]  comparator_dout,
    output logic [9:0]  waveform_addr,
    output logic        can_commit,
    output logic [11:0] pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_W = 10'(V_ACTIVE);
    localparam logic [9:0]  INT_BASE_W = 10'(INT_BASE);
    localparam logic [9:0]  CMP_BASE_W = 10'(CMP_BASE);

    typedef enum logic {
        DRAW   = 1'b0,
        VBLANK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic        can_commit_q, can_commit_d;

    // stage A
    logic [9:0]  addr_q,  addr_d;
    logic        oor_a_q, oor_a_d;
    logic [9:0]  vc_a_q,  vc_a_d;
    logic        hs_a_q,  hs_a_d;
    logic        vs_a_q,  vs_a_d;
    logic        bl_a_q,  bl_a_d;

    // stage B
    logic        oor_b_q, oor_b_d;
    logic [9:0]  vc_b_q,  vc_b_d;
    logic        hs_b_q,  hs_b_d;
    logic        vs_b_q,  vs_b_d;
    logic        bl_b_q,  bl_b_d;

    // stage C
    logic [11:0] pixel_q, pixel_d;
    logic        hs_c_q,  hs_c_d;
    logic        vs_c_q,  vs_c_d;
    logic        bl_c_q,  bl_c_d;

`ifdef WAVEFORM_CONNECT_EN
    // col0 marks the first column of a line; val marks a real sample (not a
    // reset-filled pipeline slot) so prev only ever holds genuine rows.
    logic        col0_a_q, col0_a_d;
    logic        col0_b_q, col0_b_d;
    logic        val_a_q,  val_a_d;
    logic        val_b_q,  val_b_d;
    logic [9:0]  prev_i_q, prev_i_d;
    logic [9:0]  prev_c_q, prev_c_d;
`endif

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [9:0]  row_i;
    logic [9:0]  row_c;
    logic        hit_i;
    logic        hit_c;

    // Base rows are at least 1023 >> VSHIFT, so these never wrap.
    always_comb begin
        row_i = INT_BASE_W - (integrator_dout >> VSHIFT);
        row_c = CMP_BASE_W - (comparator_dout >> VSHIFT);
    end

`ifdef WAVEFORM_CONNECT_EN
    logic [9:0] prev_i_eff, prev_c_eff;
    logic [9:0] lo_i, hi_i, lo_c, hi_c;

    always_comb begin
        // At column 0 the previous sample belongs to the last line; treat
        // it as equal to the current row so no segment crosses line start.
        prev_i_eff = col0_b_q ? row_i : prev_i_q;
        prev_c_eff = col0_b_q ? row_c : prev_c_q;
        lo_i  = (prev_i_eff < row_i) ? prev_i_eff : row_i;
        hi_i  = (prev_i_eff < row_i) ? row_i : prev_i_eff;
        lo_c  = (prev_c_eff < row_c) ? prev_c_eff : row_c;
        hi_c  = (prev_c_eff < row_c) ? row_c : prev_c_eff;
        hit_i = (vc_b_q >= lo_i) && (vc_b_q <= hi_i);
        hit_c = (vc_b_q >= lo_c) && (vc_b_q <= hi_c);
        prev_i_d = val_b_q ? row_i : prev_i_q;
        prev_c_d = val_b_q ? row_c : prev_c_q;
    end
`else
    always_comb begin
        hit_i = (vc_b_q == row_i);
        hit_c = (vc_b_q == row_c);
    end
`endif

    // Raster pipeline
    always_comb begin
        addr_d  = hcount[9:0];
        oor_a_d = (hcount >= H_ACTIVE_W);
        vc_a_d  = vcount;
        hs_a_d  = hsync_in;
        vs_a_d  = vsync_in;
        bl_a_d  = blank_in;

        oor_b_d = oor_a_q;
        vc_b_d  = vc_a_q;
        hs_b_d  = hs_a_q;
        vs_b_d  = vs_a_q;
        bl_b_d  = bl_a_q;

        hs_c_d  = hs_b_q;
        vs_c_d  = vs_b_q;
        bl_c_d  = bl_b_q;

`ifdef WAVEFORM_CONNECT_EN
        col0_a_d = (hcount == 11'd0);
        col0_b_d = col0_a_q;
        val_a_d  = 1'b1;
        val_b_d  = val_a_q;
`endif
    end

    // Pixel select; integrator drawn on top of comparator.
    always_comb begin
        pixel_d = 12'h000;
        if (!bl_b_q && !oor_b_q) begin
            if (hit_i) begin
                pixel_d = INT_COLOR;
            end else if (hit_c) begin
                pixel_d = CMP_COLOR;
            end
        end
    end

    // Commit FSM: one permission pulse per frame, at the first V_ACTIVE row.
    always_comb begin
        state_d      = state_q;
        can_commit_d = 1'b0;
        case (state_q)
            DRAW: begin
                if (vcount == V_ACTIVE_W) begin
                    state_d      = VBLANK;
                    can_commit_d = ~freeze;
                end
            end
            VBLANK: begin
                if (vcount == 10'd0) begin
                    state_d = DRAW;
                end
            end
            default: state_d = DRAW;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DRAW;
            can_commit_q <= 1'b0;
            addr_q       <= 10'd0;
            oor_a_q      <= 1'b0;
            vc_a_q       <= 10'd0;
            hs_a_q       <= 1'b0;
            vs_a_q       <= 1'b0;
            bl_a_q       <= 1'b1;
            oor_b_q      <= 1'b0;
            vc_b_q       <= 10'd0;
            hs_b_q       <= 1'b0;
            vs_b_q       <= 1'b0;
            bl_b_q       <= 1'b1;
            pixel_q      <= 12'h000;
            hs_c_q       <= 1'b0;
            vs_c_q       <= 1'b0;
            bl_c_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            can_commit_q <= can_commit_d;
            addr_q       <= addr_d;
            oor_a_q      <= oor_a_d;
            vc_a_q       <= vc_a_d;
            hs_a_q       <= hs_a_d;
            vs_a_q       <= vs_a_d;
            bl_a_q       <= bl_a_d;
            oor_b_q      <= oor_b_d;
            vc_b_q       <= vc_b_d;
            hs_b_q       <= hs_b_d;
            vs_b_q       <= vs_b_d;
            bl_b_q       <= bl_b_d;
            pixel_q      <= pixel_d;
            hs_c_q       <= hs_c_d;
            vs_c_q       <= vs_c_d;
            bl_c_q       <= bl_c_d;
        end
    end

`ifdef WAVEFORM_CONNECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col0_a_q <= 1'b0;
            col0_b_q <= 1'b0;
            val_a_q  <= 1'b0;
            val_b_q  <= 1'b0;
            prev_i_q <= 10'd0;
            prev_c_q <= 10'd0;
        end else begin
            col0_a_q <= col0_a_d;
            col0_b_q <= col0_b_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            prev_i_q <= prev_i_d;
            prev_c_q <= prev_c_d;
        end
    end
`endif

    assign waveform_addr = addr_q;
    assign can_commit    = can_commit_q;
    assign pixel         = pixel_q;
    assign hsync_out     = hs_c_q;
    assign vsync_out     = vs_c_q;
    assign blank_out     = bl_c_q;

endmodule
